// File: rtl/cam_pkg.sv
// Shared definitions for the CAM entry-RAM write path.
// Contents: entry/word/beat geometry, the write-sequencer state type and
// the beat-select helper. The CLEAR state is present only when
// CAM_RAM_WR_CLEAR_EN is defined.
package cam_pkg;

  localparam int unsigned CAM_ENTRY_W = 288;
  localparam int unsigned CAM_WORD_W  = 36;
  localparam int unsigned CAM_BEATS   = 8;
  localparam int unsigned CAM_BEAT_W  = 3;

`ifdef CAM_RAM_WR_CLEAR_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } cam_wr_state_t;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } cam_wr_state_t;
`endif

  // Beat j is entry[36*(j+1)-1 -: 36]; a packed reshape gives exactly that order.
  function automatic logic [CAM_WORD_W-1:0] cam_beat_word(
    input logic [CAM_ENTRY_W-1:0] entry,
    input logic [CAM_BEAT_W-1:0]  beat
  );
    logic [CAM_BEATS-1:0][CAM_WORD_W-1:0] words;
    words = entry;
    return words[beat];
  endfunction

endpackage

// File: rtl/cam_ram_wr_ctrl_if.sv
// Request and RAM-write bundle of cam_ram_wr_ctrl.
// master: table-management side (drives req_*, clr_start, observes the rest).
// slave : the write sequencer (drives req_ready, clr_busy, ram_*, wr_done).
interface cam_ram_wr_ctrl_if #(
  parameter int unsigned CAM_DEPTH = 1024
);
  import cam_pkg::*;

  localparam int unsigned IDX_W  = $clog2(CAM_DEPTH);
  localparam int unsigned ADDR_W = IDX_W + CAM_BEAT_W;

  logic                   req_valid;
  logic                   req_ready;
  logic [IDX_W-1:0]       req_index;
  logic [CAM_ENTRY_W-1:0] req_data;
  logic                   clr_start;
  logic                   clr_busy;
  logic [ADDR_W-1:0]      ram_addra;
  logic                   ram_wea;
  logic [CAM_WORD_W-1:0]  ram_dina;
  logic                   wr_done;

  modport master (
    output req_valid, req_index, req_data, clr_start,
    input  req_ready, clr_busy, ram_addra, ram_wea, ram_dina, wr_done
  );

  modport slave (
    input  req_valid, req_index, req_data, clr_start,
    output req_ready, clr_busy, ram_addra, ram_wea, ram_dina, wr_done
  );

endinterface

// File: rtl/cam_ram_wr_ctrl.sv
// Write sequencer for the CAM entry RAM: takes 288-bit entries and writes
// them as eight 36-bit beats on the RAM narrow port; optional bulk clear.
// Ports: clka (clock), reset (async, active-high), bus (cam_ram_wr_ctrl_if.slave).
// Build option: CAM_RAM_WR_CLEAR_EN builds the CLEAR sweep; otherwise
// clr_start is ignored and clr_busy is tied low.
module cam_ram_wr_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned CAM_DEPTH                   = 1024,
  parameter int unsigned C_BRAM_PRIMITIVE_ADDR_WIDTH = 10
) (
  input  logic        clka,
  input  logic        reset,
  cam_ram_wr_ctrl_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(CAM_DEPTH);
  localparam int unsigned ADDR_W = IDX_W + CAM_BEAT_W;
  localparam logic [CAM_BEAT_W-1:0] LAST_BEAT = CAM_BEAT_W'(CAM_BEATS - 1);

  // Depth must tile whole BRAM primitives and be a power of two.
  if ((CAM_DEPTH % (2 ** C_BRAM_PRIMITIVE_ADDR_WIDTH)) != 0) begin : g_depth_tile_chk
    $error("CAM_DEPTH must be a multiple of 2**C_BRAM_PRIMITIVE_ADDR_WIDTH");
  end
  if ((CAM_DEPTH & (CAM_DEPTH - 1)) != 0) begin : g_depth_pow2_chk
    $error("CAM_DEPTH must be a power of two");
  end

  cam_wr_state_t          state_q, state_d;
  logic [CAM_BEAT_W-1:0]  beat_q, beat_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CAM_ENTRY_W-1:0] data_q, data_d;

  logic [ADDR_W-1:0]      addra_q, addra_d;
  logic                   wea_q, wea_d;
  logic [CAM_WORD_W-1:0]  dina_q, dina_d;
  logic                   done_q, done_d;

  logic                   ready_c;
  logic                   accept_c;

`ifdef CAM_RAM_WR_CLEAR_EN
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(CAM_BEATS * CAM_DEPTH - 1);
  logic              clr_pend_q, clr_pend_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
`else
  logic unused_clr_start;
  assign unused_clr_start = bus.clr_start;
`endif

  // Ready depends only on state and pending clear, never on req_valid.
  always_comb begin
    ready_c = 1'b0;
    if (!reset) begin
      if (state_q == ST_IDLE) ready_c = 1'b1;
      if (state_q == ST_WRITE && beat_q == LAST_BEAT) ready_c = 1'b1;
`ifdef CAM_RAM_WR_CLEAR_EN
      if (clr_pend_q) ready_c = 1'b0;
`endif
    end
  end

  assign accept_c = bus.req_valid & ready_c;

  // Next-state: beat sequencing, request latch, clear bookkeeping.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef CAM_RAM_WR_CLEAR_EN
    clr_pend_d = clr_pend_q;
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_WRITE;
          beat_d  = '0;
          idx_d   = bus.req_index;
          data_d  = bus.req_data;
        end
      end
      ST_WRITE: begin
        if (beat_q != LAST_BEAT) begin
          beat_d = beat_q + CAM_BEAT_W'(1);
        end else if (accept_c) begin
          beat_d = '0;
          idx_d  = bus.req_index;
          data_d = bus.req_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef CAM_RAM_WR_CLEAR_EN
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef CAM_RAM_WR_CLEAR_EN
    // A sweep already running absorbs further clr_start pulses.
    if (state_q != ST_CLEAR && bus.clr_start) clr_pend_d = 1'b1;
    // Wherever the FSM would idle, a pending clear takes over instead.
    if (state_d == ST_IDLE && clr_pend_d) begin
      state_d    = ST_CLEAR;
      clr_pend_d = 1'b0;
      cnt_d      = '0;
    end
`endif
  end

  // Outputs are registered from the next state so beat 0 appears right after acceptance.
  always_comb begin
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    done_d  = (state_q == ST_WRITE) && (beat_q == LAST_BEAT);
`ifdef CAM_RAM_WR_CLEAR_EN
    busy_d  = 1'b0;
`endif
    case (state_d)
      ST_WRITE: begin
        wea_d   = 1'b1;
        addra_d = {idx_d, beat_d};
        dina_d  = cam_beat_word(data_d, beat_d);
      end
`ifdef CAM_RAM_WR_CLEAR_EN
      ST_CLEAR: begin
        wea_d   = 1'b1;
        addra_d = cnt_d;
        dina_d  = '0;
        busy_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef CAM_RAM_WR_CLEAR_EN
      clr_pend_q <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
`ifdef CAM_RAM_WR_CLEAR_EN
      clr_pend_q <= clr_pend_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Output registers; async reset drops the write strobe immediately.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      addra_q <= '0;
      wea_q   <= 1'b0;
      dina_q  <= '0;
      done_q  <= 1'b0;
`ifdef CAM_RAM_WR_CLEAR_EN
      busy_q  <= 1'b0;
`endif
    end else begin
      addra_q <= addra_d;
      wea_q   <= wea_d;
      dina_q  <= dina_d;
      done_q  <= done_d;
`ifdef CAM_RAM_WR_CLEAR_EN
      busy_q  <= busy_d;
`endif
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.ram_addra = addra_q;
  assign bus.ram_wea   = wea_q;
  assign bus.ram_dina  = dina_q;
  assign bus.wr_done   = done_q;
`ifdef CAM_RAM_WR_CLEAR_EN
  assign bus.clr_busy  = busy_q;
`else
  assign bus.clr_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_cam_ram_wr_ctrl.sv
// Self-checking bench for cam_ram_wr_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based write model.
module tb_cam_ram_wr_ctrl;
  import cam_pkg::*;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned NWORDS = DEPTH * CAM_BEATS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_ram_wr_ctrl_if #(.CAM_DEPTH(DEPTH)) bus ();

  cam_ram_wr_ctrl #(.CAM_DEPTH(DEPTH), .C_BRAM_PRIMITIVE_ADDR_WIDTH(10)) dut (
    .clka  (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // BRAM write-port image, filled from the DUT's strobes.
  logic [CAM_WORD_W-1:0] mem [NWORDS];

  // Reference model: queue of RAM writes still to be presented.
  typedef struct {
    logic [ADDR_W-1:0]     addr;
    logic [CAM_WORD_W-1:0] data;
    bit                    is_clr;
    bit                    last;
  } wr_item_t;

  wr_item_t pend[$];
  wr_item_t cur;
  bit       cur_valid;
  bit       clr_pend_m;
  bit       done_m;

  typedef struct {
    bit                    v;
    logic [IDX_W-1:0]      idx;
    int                    seed;
    bit                    e_rdy;
    bit                    e_wea;
    logic [ADDR_W-1:0]     e_addr;
    logic [CAM_WORD_W-1:0] e_dina;
    bit                    e_done;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mkv(bit v, int idx, int seed, bit rdy, bit wea, int addr, int dina, bit done);
    vec_t r;
    r.v = v; r.idx = IDX_W'(idx); r.seed = seed;
    r.e_rdy = rdy; r.e_wea = wea; r.e_addr = ADDR_W'(addr);
    r.e_dina = CAM_WORD_W'(dina); r.e_done = done;
    return r;
  endfunction

  // Entry whose word j is seed*16 + j.
  function automatic logic [CAM_ENTRY_W-1:0] make_entry(int seed);
    logic [CAM_BEATS-1:0][CAM_WORD_W-1:0] w;
    for (int j = 0; j < CAM_BEATS; j++) w[j] = CAM_WORD_W'(seed * 16 + j);
    return w;
  endfunction

  function automatic logic [CAM_ENTRY_W-1:0] rand_entry();
    logic [8:0][31:0] r;
    for (int k = 0; k < 9; k++) r[k] = $urandom();
    return r;
  endfunction

  function automatic bit model_ready();
    return !rst && pend.size() == 0 && !clr_pend_m && !(cur_valid && cur.is_clr);
  endfunction

  task automatic model_reset();
    pend.delete();
    cur.addr = '0; cur.data = '0; cur.is_clr = 1'b0; cur.last = 1'b0;
    cur_valid = 1'b0; clr_pend_m = 1'b0; done_m = 1'b0;
  endtask

  task automatic model_step(bit v, logic [IDX_W-1:0] idx, logic [CAM_ENTRY_W-1:0] d, bit c, bit rdy);
    logic [CAM_BEATS-1:0][CAM_WORD_W-1:0] w;
    wr_item_t it;
    w = d;
    done_m = cur_valid && cur.last && !cur.is_clr;
    if (v && rdy) begin
      for (int j = 0; j < CAM_BEATS; j++) begin
        it.addr = {idx, CAM_BEAT_W'(j)};
        it.data = w[CAM_BEAT_W'(j)];
        it.is_clr = 1'b0;
        it.last = (j == CAM_BEATS - 1);
        pend.push_back(it);
      end
    end
`ifdef CAM_RAM_WR_CLEAR_EN
    if (c && !(cur_valid && cur.is_clr)) clr_pend_m = 1'b1;
    if (pend.size() == 0 && clr_pend_m) begin
      for (int a = 0; a < NWORDS; a++) begin
        it.addr = ADDR_W'(a); it.data = '0; it.is_clr = 1'b1; it.last = 1'b0;
        pend.push_back(it);
      end
      clr_pend_m = 1'b0;
    end
`else
    if (c) clr_pend_m = 1'b0;
`endif
    if (pend.size() != 0) begin
      cur = pend.pop_front();
      cur_valid = 1'b1;
    end else begin
      cur_valid = 1'b0;
    end
  endtask

  function automatic logic [63:0] exp_outs();
    return 64'({model_ready(), cur_valid, cur.addr, cur.data, done_m, cur_valid && cur.is_clr});
  endfunction

  function automatic logic [63:0] act_outs();
    return 64'({bus.req_ready, bus.ram_wea, bus.ram_addra, bus.ram_dina, bus.wr_done, bus.clr_busy});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  // One clock: drive inputs, let the RAM image capture, step model, compare.
  task automatic cycle(bit v, logic [IDX_W-1:0] idx, logic [CAM_ENTRY_W-1:0] d, bit c);
    bit rdy;
    bus.req_valid = v; bus.req_index = idx; bus.req_data = d; bus.clr_start = c;
    rdy = model_ready();
    if (bus.ram_wea === 1'b1) mem[bus.ram_addra] = bus.ram_dina;
    @(posedge clk);
    model_step(v, idx, d, c, rdy);
    #1;
    chk("outs", act_outs(), exp_outs());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int run, maxrun, ndone, t, busy_cnt, rdy_bad, wea_cnt;
    int done_at[$];
    bit seen_busy;

    for (int a = 0; a < NWORDS; a++) mem[a] = '0;
    bus.req_valid = 1'b0; bus.req_index = '0; bus.req_data = '0; bus.clr_start = 1'b0;
    model_reset();

    // Directed table: write idx 5, then idx 2 offered during beats 0..6 and taken in beat 7.
    tbl[0] = mkv(1, 5, 0, 0, 1, 40, 0, 0);
    for (int k = 1; k <= 6; k++) tbl[k] = mkv(1, 2, 1, 0, 1, 40 + k, k, 0);
    tbl[7] = mkv(1, 2, 1, 1, 1, 47, 7, 0);
    tbl[8] = mkv(1, 2, 1, 0, 1, 16, 16, 1);
    for (int k = 1; k <= 7; k++) tbl[8 + k] = mkv(0, 0, 0, (k == 7), 1, 16 + k, 16 + k, 0);
    tbl[16] = mkv(0, 0, 0, 1, 0, 23, 23, 1);
    tbl[17] = mkv(0, 0, 0, 1, 0, 23, 23, 0);

    // Reset state.
    #2;
    chk("reset_outs", act_outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_reset", act_outs(), exp_outs());

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].v, tbl[i].idx, make_entry(tbl[i].seed), 1'b0);
      chk($sformatf("tbl%0d", i),
          64'({bus.req_ready, bus.ram_wea, bus.ram_addra, bus.ram_dina, bus.wr_done}),
          64'({tbl[i].e_rdy, tbl[i].e_wea, tbl[i].e_addr, tbl[i].e_dina, tbl[i].e_done}));
    end
    for (int j = 0; j < CAM_BEATS; j++) begin
      chk("read_entry5", 64'(mem[ADDR_W'(40 + j)]), 64'(j));
      chk("read_entry2", 64'(mem[ADDR_W'(16 + j)]), 64'(16 + j));
    end

    // Back-to-back: index 0 then 1023 with valid held.
    run = 0; maxrun = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(c <= 8, (c == 0) ? IDX_W'(0) : IDX_W'(1023), make_entry((c == 0) ? 3 : 4), 1'b0);
      if (bus.ram_wea === 1'b1) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (bus.wr_done === 1'b1) done_at.push_back(c);
      if (c == 8) chk("b2b_second_addr", 64'(bus.ram_addra), 64'd8184);
      if (c == 15) chk("b2b_last_addr", 64'(bus.ram_addra), 64'd8191);
    end
    chk("b2b_wea_run", 64'(maxrun), 64'd16);
    chk("b2b_done_cnt", 64'(done_at.size()), 64'd2);
    if (done_at.size() == 2) chk("b2b_done_gap", 64'(done_at[1] - done_at[0]), 64'd8);

    // Reset in beat 3 of index 2.
    for (int c = 0; c < 4; c++) cycle(c == 0, IDX_W'(2), make_entry(5), 1'b0);
    chk("pre_rst_beat3", 64'(bus.ram_addra), 64'd19);
    #2; rst = 1'b1; #1;
    chk("rst_wea_async", 64'({bus.ram_wea, bus.wr_done, bus.req_ready}), 64'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("rst_release_ready", 64'(bus.req_ready), 64'd1);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, '0, '0, 1'b0);
      if (bus.wr_done === 1'b1) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'd0);

`ifdef CAM_RAM_WR_CLEAR_EN
    // Clear requested together with a write to index 7.
    cycle(1'b1, IDX_W'(7), make_entry(6), 1'b1);
    chk("clr_first_beat", 64'(bus.ram_addra), 64'd56);
    t = 0; busy_cnt = 0; rdy_bad = 0; seen_busy = 1'b0;
    while (t < 9000 && !(seen_busy && bus.clr_busy !== 1'b1)) begin
      cycle(1'b0, '0, '0, 1'b0);
      t++;
      if (bus.clr_busy === 1'b1) begin
        busy_cnt++;
        seen_busy = 1'b1;
        if (bus.req_ready !== 1'b0) rdy_bad++;
      end
    end
    chk("clr_timeout", 64'(t < 9000), 64'd1);
    chk("clr_busy_len", 64'(busy_cnt), 64'(NWORDS));
    chk("clr_ready_low", 64'(rdy_bad), 64'd0);
    for (int j = 0; j < CAM_BEATS; j++) begin
      chk("clr_entry7", 64'(mem[ADDR_W'(56 + j)]), 64'd0);
      chk("clr_entry5", 64'(mem[ADDR_W'(40 + j)]), 64'd0);
    end
`else
    // Clear requested in a build without the sweep: nothing happens.
    cycle(1'b0, '0, '0, 1'b1);
    wea_cnt = (bus.ram_wea === 1'b1) ? 1 : 0;
    busy_cnt = (bus.clr_busy === 1'b1) ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, '0, '0, 1'b0);
      if (bus.ram_wea === 1'b1) wea_cnt++;
      if (bus.clr_busy === 1'b1) busy_cnt++;
    end
    chk("noclr_wea", 64'(wea_cnt), 64'd0);
    chk("noclr_busy", 64'(busy_cnt), 64'd0);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      cycle($urandom_range(0, 9) < 6, IDX_W'($urandom_range(0, DEPTH - 1)), rand_entry(),
            $urandom_range(0, 2999) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
